down_mixer: RTL and testbench
=============================

// Module: down_mixer
// PURPOSE
//  Complex digital down-conversion mixer for the readout chain.
//  - Multiplies input sample x = i_in_1 + j*q_in_1 by the conjugate of LO sample y = i_in_2 + j*q_in_2.
//  - Computes i_out = i1*i2 + q1*q2 and q_out = q1*i2 - i1*q2, i.e. the phase difference x minus y.
//  - Sits between the ADC/NCO sample stream and the demodulation integrator.
// PARAMETERS
//  INPUT_WIDTH   16               width of all four inputs, signed two's complement, Q1.(INPUT_WIDTH-1)
//  OUTPUT_WIDTH  16               width of i_out/q_out, signed two's complement
//  FRAC_BITS     INPUT_WIDTH-1    right shift applied to the product sum (LO full scale = 1.0)
// PORTS
//  clk       in   1             single clock, all logic rising-edge
//  rst_n     in   1             asynchronous active-low reset
//  in_valid  in   1             inputs valid this cycle
//  i_in_1    in   INPUT_WIDTH   signal I (signed)
//  q_in_1    in   INPUT_WIDTH   signal Q (signed)
//  i_in_2    in   INPUT_WIDTH   LO I / cos (signed)
//  q_in_2    in   INPUT_WIDTH   LO Q / sin (signed)
//  out_valid out  1             i_out/q_out valid
//  i_out     out  OUTPUT_WIDTH  mixed I (signed)
//  q_out     out  OUTPUT_WIDTH  mixed Q (signed)
// BEHAVIOUR
//  - Reset: rst_n=0 asynchronously clears all pipeline registers.
//    - i_out=0, q_out=0, out_valid=0 while reset is held and after release.
//  - Pipeline: fixed 2-cycle latency, no backpressure, one sample per clock.
//    - Stage 1 registers the four signed products p_ii=i1*i2, p_qq=q1*q2, p_qi=q1*i2, p_iq=i1*q2.
//      Each product is 2*INPUT_WIDTH bits.
//    - Stage 2 registers the outputs.
//      - i_sum = p_ii + p_qq and q_sum = p_qi - p_iq, each 2*INPUT_WIDTH+1 bits, no overflow possible.
//      - Round half up: add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
//      - Saturate to OUTPUT_WIDTH signed range; 16-bit range is [-32768, 32767].
//  - out_valid is in_valid delayed 2 cycles.
//    - Data registers update every cycle regardless of in_valid. Downstream qualifies with out_valid.
//  - Sign extension of narrower sources is the caller's job; inputs are always treated as signed.
//  - The only overflow corner is i1=q1=i2=q2=-2^(W-1). There i_sum=2^(2W-1) and the output saturates to +max.
//  - Reset asserted mid-stream discards in-flight samples. First valid output comes 2 cycles after the first in_valid following release.
// STRUCTURE
//  - Package down_mixer_pkg:
//    - default widths;
//    - PROD_W = 2*INPUT_WIDTH, SUM_W = PROD_W+1;
//    - function sat_round(sum) returning OUTPUT_WIDTH.
//  - One sub-module, mixer_round_sat, holds the stage-2 round+saturate datapath and is instantiated for I and Q.
//  - Top holds the stage-1 product registers and the valid shift register.
// TESTING
//  1) Reset:
//     - Hold rst_n=0 with inputs at full scale -> i_out=0, q_out=0, out_valid=0.
//     - Release -> outputs stay 0 until valid data arrives.
//  2) i1=127, q1=0, i2=32767, q2=0, in_valid=1 -> after 2 clocks i_out=127, q_out=0, out_valid=1.
//     - Check: 4161409>>>15 rounds to 127.
//  3) i1=0, q1=127, i2=32767, q2=0 -> i_out=0, q_out=127.
//  4) i1=127, q1=0, i2=0, q2=32767 -> i_out=0, q_out=-127 (0xFF81).
//  5) Saturation corner: all four inputs = -32768 (0x8000) -> i_out=32767 (saturated), q_out=0.
//  6) Streaming tones, 1024-entry sin/cos LUTs advancing one entry per clock.
//     - Signal tone is 8-bit amplitude 127 sign-extended; LO tone is 16-bit amplitude 32767.
//     - Phase offset 0 -> steady i_out=127+-1, q_out=0+-1.
//     - Offset 128 entries (45 deg) -> i_out=q_out=90+-1.
//     - Offset 256 -> i_out=0+-1, q_out=127+-1.
//     - Output holds constant across LUT wrap from entry 1023 to 0.

Source files
------------

// File: rtl/down_mixer_pkg.sv
// Shared widths and the reference round/saturate helper for the down-conversion mixer.
// The sub-module implements the same arithmetic for arbitrary widths.
package down_mixer_pkg;

    localparam int DEF_INPUT_WIDTH  = 16;
    localparam int DEF_OUTPUT_WIDTH = 16;
    localparam int DEF_FRAC_BITS    = DEF_INPUT_WIDTH - 1;
    localparam int PROD_W           = 2 * DEF_INPUT_WIDTH;
    localparam int SUM_W            = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        (SUM_W'(1) << (DEF_OUTPUT_WIDTH - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [SUM_W-1:0] ROUND_HALF = SUM_W'(1) << (DEF_FRAC_BITS - 1);

    // Round half up, drop the fractional bits, clamp to the default output range.
    function automatic logic signed [DEF_OUTPUT_WIDTH-1:0] sat_round(
        input logic signed [SUM_W-1:0] sum
    );
        logic signed [SUM_W-1:0] rounded;
        logic signed [SUM_W-1:0] shifted;
        rounded = sum + ROUND_HALF;
        shifted = rounded >>> DEF_FRAC_BITS;
        if (shifted > SAT_MAX) begin
            return SAT_MAX[DEF_OUTPUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            return SAT_MIN[DEF_OUTPUT_WIDTH-1:0];
        end
        return shifted[DEF_OUTPUT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mixer_round_sat.sv
// Stage-2 output register: rounds a full-precision product sum half up,
// shifts out the fractional bits and saturates to the output width.
module mixer_round_sat
    import down_mixer_pkg::*;
#(
    parameter int SUM_WIDTH    = SUM_W,
    parameter int FRAC_BITS    = DEF_FRAC_BITS,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [SUM_WIDTH-1:0]    sum,
    output logic signed [OUTPUT_WIDTH-1:0] result
);

    localparam logic signed [SUM_WIDTH-1:0] HALF  = SUM_WIDTH'(1) << (FRAC_BITS - 1);
    localparam logic signed [SUM_WIDTH-1:0] MAX_V =
        (SUM_WIDTH'(1) << (OUTPUT_WIDTH - 1)) - SUM_WIDTH'(1);
    localparam logic signed [SUM_WIDTH-1:0] MIN_V = ~MAX_V;

    logic signed [SUM_WIDTH-1:0]    rounded;
    logic signed [SUM_WIDTH-1:0]    shifted;
    logic signed [OUTPUT_WIDTH-1:0] sat_value;

    // The sum carries one guard bit, so adding the half LSB can never wrap.
    always_comb begin
        rounded = sum + HALF;
        shifted = rounded >>> FRAC_BITS;
        if (shifted > MAX_V) begin
            sat_value = MAX_V[OUTPUT_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            sat_value = MIN_V[OUTPUT_WIDTH-1:0];
        end else begin
            sat_value = shifted[OUTPUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else begin
            result <= sat_value;
        end
    end

endmodule

// File: rtl/down_mixer.sv
// Complex down-conversion mixer: x * conj(y) with a two-stage pipeline
// (registered products, then registered round/saturate outputs).
module down_mixer
    import down_mixer_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int FRAC_BITS    = INPUT_WIDTH - 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic signed [INPUT_WIDTH-1:0]  i_in_1,
    input  logic signed [INPUT_WIDTH-1:0]  q_in_1,
    input  logic signed [INPUT_WIDTH-1:0]  i_in_2,
    input  logic signed [INPUT_WIDTH-1:0]  q_in_2,
    output logic                           out_valid,
    output logic signed [OUTPUT_WIDTH-1:0] i_out,
    output logic signed [OUTPUT_WIDTH-1:0] q_out
);

    localparam int PROD_WIDTH = 2 * INPUT_WIDTH;
    localparam int SUM_WIDTH  = PROD_WIDTH + 1;

    logic signed [PROD_WIDTH-1:0] p_ii;
    logic signed [PROD_WIDTH-1:0] p_qq;
    logic signed [PROD_WIDTH-1:0] p_qi;
    logic signed [PROD_WIDTH-1:0] p_iq;
    logic signed [SUM_WIDTH-1:0]  i_sum;
    logic signed [SUM_WIDTH-1:0]  q_sum;
    logic [1:0]                   valid_pipe;

    // Products update every cycle; out_valid alone qualifies the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_ii       <= '0;
            p_qq       <= '0;
            p_qi       <= '0;
            p_iq       <= '0;
            valid_pipe <= '0;
        end else begin
            p_ii       <= PROD_WIDTH'(i_in_1) * PROD_WIDTH'(i_in_2);
            p_qq       <= PROD_WIDTH'(q_in_1) * PROD_WIDTH'(q_in_2);
            p_qi       <= PROD_WIDTH'(q_in_1) * PROD_WIDTH'(i_in_2);
            p_iq       <= PROD_WIDTH'(i_in_1) * PROD_WIDTH'(q_in_2);
            valid_pipe <= {valid_pipe[0], in_valid};
        end
    end

    assign i_sum     = SUM_WIDTH'(p_ii) + SUM_WIDTH'(p_qq);
    assign q_sum     = SUM_WIDTH'(p_qi) - SUM_WIDTH'(p_iq);
    assign out_valid = valid_pipe[1];

    mixer_round_sat #(
        .SUM_WIDTH    (SUM_WIDTH),
        .FRAC_BITS    (FRAC_BITS),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_round_i (
        .clk    (clk),
        .rst_n  (rst_n),
        .sum    (i_sum),
        .result (i_out)
    );

    mixer_round_sat #(
        .SUM_WIDTH    (SUM_WIDTH),
        .FRAC_BITS    (FRAC_BITS),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_round_q (
        .clk    (clk),
        .rst_n  (rst_n),
        .sum    (q_sum),
        .result (q_out)
    );

endmodule

// File: tb/tb_down_mixer.sv
// Directed-vector bench for down_mixer: reset, hand-computed products, rounding ties,
// saturation corner, valid latency, mid-stream reset and streaming sin/cos tones.
module tb_down_mixer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] i_in_1;
    logic signed [15:0] q_in_1;
    logic signed [15:0] i_in_2;
    logic signed [15:0] q_in_2;
    logic               out_valid;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;

    int checkCount = 0;
    int errorCount = 0;

    int cosSig [1024];
    int sinSig [1024];
    int cosLo  [1024];
    int sinLo  [1024];

    always #5 clk = ~clk;

    down_mixer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .i_in_1    (i_in_1),
        .q_in_1    (q_in_1),
        .i_in_2    (i_in_2),
        .q_in_2    (q_in_2),
        .out_valid (out_valid),
        .i_out     (i_out),
        .q_out     (q_out)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected,
                               input int tol);
        checkCount++;
        if (observed > expected + tol || observed < expected - tol) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (tol %0d) at %0t",
                     tag, observed, expected, tol, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, well clear of the capture edge.
    task automatic applyStimulus(input logic v, input int a, input int b, input int c,
                                 input int d);
        @(posedge clk);
        #1;
        in_valid = v;
        i_in_1   = 16'(a);
        q_in_1   = 16'(b);
        i_in_2   = 16'(c);
        q_in_2   = 16'(d);
    endtask

    task automatic runVector(input string tag, input int a, input int b, input int c,
                             input int d, input int expI, input int expQ);
        applyStimulus(1'b1, a, b, c, d);
        applyStimulus(1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_i"}, int'(i_out), expI, 0);
        checkOutput({tag, "_q"}, int'(q_out), expQ, 0);
        checkOutput({tag, "_valid"}, int'(out_valid), 1, 0);
    endtask

    // Signal leads the LO by 'offset' LUT entries; outputs lag the inputs by two iterations.
    task automatic runTone(input string tag, input int offset, input int expI, input int expQ);
        int k;
        int s;
        for (int n = 0; n < 1100; n++) begin
            @(posedge clk);
            #1;
            if (n >= 2) begin
                checkOutput({tag, "_i"}, int'(i_out), expI, 1);
                checkOutput({tag, "_q"}, int'(q_out), expQ, 1);
                checkOutput({tag, "_valid"}, int'(out_valid), 1, 0);
            end
            k        = n % 1024;
            s        = (k + offset) % 1024;
            in_valid = 1'b1;
            i_in_1   = 16'(cosSig[s]);
            q_in_1   = 16'(sinSig[s]);
            i_in_2   = 16'(cosLo[k]);
            q_in_2   = 16'(sinLo[k]);
        end
        applyStimulus(1'b0, 0, 0, 0, 0);
    endtask

    function automatic int roundReal(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        real ph;
        for (int k = 0; k < 1024; k++) begin
            ph        = 2.0 * 3.14159265358979 * real'(k) / 1024.0;
            cosSig[k] = roundReal(127.0 * $cos(ph));
            sinSig[k] = roundReal(127.0 * $sin(ph));
            cosLo[k]  = roundReal(32767.0 * $cos(ph));
            sinLo[k]  = roundReal(32767.0 * $sin(ph));
        end

        // Reset held with full-scale valid inputs must keep everything cleared.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        i_in_1   = 16'sh7FFF;
        q_in_1   = 16'sh7FFF;
        i_in_2   = 16'sh7FFF;
        q_in_2   = 16'sh7FFF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_hold_i", int'(i_out), 0, 0);
        checkOutput("rst_hold_q", int'(q_out), 0, 0);
        checkOutput("rst_hold_valid", int'(out_valid), 0, 0);

        in_valid = 1'b0;
        i_in_1   = '0;
        q_in_1   = '0;
        i_in_2   = '0;
        q_in_2   = '0;
        rst_n    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_i", int'(i_out), 0, 0);
            checkOutput("post_rst_q", int'(q_out), 0, 0);
            checkOutput("post_rst_valid", int'(out_valid), 0, 0);
        end

        runVector("i_pass", 127, 0, 32767, 0, 127, 0);
        runVector("q_pass", 0, 127, 32767, 0, 0, 127);
        runVector("neg_q", 127, 0, 0, 32767, 0, -127);
        runVector("sat_corner", -32768, -32768, -32768, -32768, 32767, 0);
        runVector("mixed_sign", -100, 50, 16384, -16384, -75, -25);
        runVector("tie_pos", 1, 0, 16384, 0, 1, 0);
        runVector("tie_neg", -1, 0, 16384, 0, 0, 0);

        // Asynchronous clear: outputs drop before the next rising edge.
        applyStimulus(1'b1, 127, 0, 32767, 0);
        applyStimulus(1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("pre_async_i", int'(i_out), 127, 0);
        rst_n = 1'b0;
        #2;
        checkOutput("async_rst_i", int'(i_out), 0, 0);
        checkOutput("async_rst_valid", int'(out_valid), 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // A sample in flight when reset pulses must never appear.
        applyStimulus(1'b1, 127, 0, 32767, 0);
        applyStimulus(1'b0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("discard_valid", int'(out_valid), 0, 0);
        end

        // First valid after release appears exactly two cycles later, for one cycle.
        applyStimulus(1'b1, 0, 127, 32767, 0);
        applyStimulus(1'b0, 0, 0, 0, 0);
        checkOutput("lat1_valid", int'(out_valid), 0, 0);
        @(posedge clk);
        #1;
        checkOutput("lat2_valid", int'(out_valid), 1, 0);
        checkOutput("lat2_q", int'(q_out), 127, 0);
        @(posedge clk);
        #1;
        checkOutput("lat3_valid", int'(out_valid), 0, 0);

        runTone("tone_0", 0, 127, 0);
        runTone("tone_45", 128, 90, 90);
        runTone("tone_90", 256, 0, 127);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
